// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants, bundle types and colour helper
// for the sprite compositor pixel pipeline.
package sprite_pkg;

  localparam int SPR_DIM = 32;
  localparam int SPR_AW = $clog2(SPR_DIM);
  localparam int ROM_AW = 2 * SPR_AW;
  localparam int VACTIVE = 480;
  localparam logic [15:0] KEY_COLOR = 16'hF81F;
  localparam logic [23:0] BG_RESET = 24'hFFFFFF;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } sprite_pos_t;

  function automatic logic [8:0] reg_en_addr(int n);
    return 9'(2 * n);
  endfunction

  function automatic logic [8:0] reg_bg_addr(int n);
    return 9'(2 * n + 1);
  endfunction

  // top bits replicated into the low bits so full-scale maps to 8'hFF
  function automatic rgb888_t rgb565_to_888(rgb565_t c);
    rgb888_t o;
    o.r = {c[15:11], c[15:13]};
    o.g = {c[10:5], c[10:9]};
    o.b = {c[4:0], c[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/sprite_compositor_hit_gen.sv
// sprite_hit_gen: per-sprite window test and ROM address
// generation, registered as pipeline stage 1.
module sprite_hit_gen
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        px,
  input  logic [9:0]        vcount,
  input  sprite_pos_t       pos,
  input  logic              en,
  output logic              hit,
  output logic [ROM_AW-1:0] rom_addr
);

  logic in_x;
  logic in_y;
  logic hit_c;
  logic [SPR_AW-1:0] dx;
  logic [SPR_AW-1:0] dy;

  // 11-bit upper bound so windows near the right/bottom never wrap
  assign in_x = (px >= pos.x) &&
                ({1'b0, px} < {1'b0, pos.x} + 11'(SPR_DIM));
  assign in_y = (vcount >= pos.y) &&
                ({1'b0, vcount} < {1'b0, pos.y} + 11'(SPR_DIM));
  assign hit_c = en && in_x && in_y;

  assign dx = SPR_AW'(px - pos.x);
  assign dy = SPR_AW'(vcount - pos.y);

  always_ff @(posedge clk) begin
    if (reset) begin
      hit      <= 1'b0;
      rom_addr <= '0;
    end else begin
      hit <= hit_c;
      if (hit_c) rom_addr <= {dy, dx};
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: double-buffered sprite registers, 3-stage
// pixel pipeline with priority layering and colour-key transparency.
module sprite_compositor #(
  parameter int          NUM_SPRITES = 6,
  parameter int          VACTIVE     = 480,
  parameter logic [15:0] KEY_COLOR   = 16'hF81F
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chipselect,
  input  logic                      write,
  input  logic [8:0]                address,
  input  logic [31:0]               writedata,
  input  logic [10:0]               hcount,
  input  logic [9:0]                vcount,
  input  logic                      blank_n_in,
  output logic [NUM_SPRITES*10-1:0] rom_addr,
  input  logic [NUM_SPRITES*16-1:0] rom_data,
  output logic [7:0]                vga_r,
  output logic [7:0]                vga_g,
  output logic [7:0]                vga_b,
  output logic                      blank_n_out
);

  import sprite_pkg::*;

  localparam logic [8:0] REG_EN = reg_en_addr(NUM_SPRITES);
  localparam logic [8:0] REG_BG = reg_bg_addr(NUM_SPRITES);

  sprite_pos_t pend_pos [NUM_SPRITES];
  sprite_pos_t act_pos  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] pend_en;
  logic [NUM_SPRITES-1:0] act_en;
  rgb888_t pend_bg;
  rgb888_t act_bg;

  logic wr;
  logic commit;
  logic is_pos;
  logic unused_wd;

  assign wr = chipselect && write;
  assign commit = (vcount == 10'(VACTIVE)) && (hcount == 11'd0);
  assign is_pos = address < REG_EN;
  assign unused_wd = ^writedata[31:24];

  // commit reads pending before this cycle's write lands
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pend_pos[i] <= '0;
        act_pos[i]  <= '0;
      end
      pend_en <= '0;
      act_en  <= '0;
      pend_bg <= BG_RESET;
      act_bg  <= BG_RESET;
    end else begin
      if (commit) begin
        act_pos <= pend_pos;
        act_en  <= pend_en;
        act_bg  <= pend_bg;
      end
      if (wr) begin
        unique case (1'b1)
          is_pos: begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
              if (address[8:1] == 8'(i)) begin
                if (address[0]) pend_pos[i].y <= writedata[9:0];
                else pend_pos[i].x <= writedata[9:0];
              end
            end
          end
          (address == REG_EN): pend_en <= writedata[NUM_SPRITES-1:0];
          (address == REG_BG): pend_bg <= writedata[23:0];
          default: ;
        endcase
      end
    end
  end

  logic [NUM_SPRITES-1:0] hit1;
  logic blank1;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    sprite_hit_gen u_hit (
      .clk      (clk),
      .reset    (reset),
      .px       (hcount[10:1]),
      .vcount   (vcount),
      .pos      (act_pos[i]),
      .en       (act_en[i]),
      .hit      (hit1[i]),
      .rom_addr (rom_addr[10*i +: 10])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) blank1 <= 1'b0;
    else blank1 <= blank_n_in;
  end

  rgb565_t rom_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit2;
  logic blank2;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) rom_q[i] <= '0;
      hit2   <= '0;
      blank2 <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        rom_q[i] <= rom_data[16*i +: 16];
      end
      hit2   <= hit1;
      blank2 <= blank1;
    end
  end

  rgb888_t pix;

  // walk from the bottom layer up so the lowest index wins
  always_comb begin
    pix = act_bg;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit2[i] && rom_q[i] != KEY_COLOR) pix = rgb565_to_888(rom_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      blank_n_out <= 1'b0;
    end else begin
      blank_n_out <= blank2;
      vga_r       <= blank2 ? pix.r : 8'd0;
      vga_g       <= blank2 ? pix.g : 8'd0;
      vga_b       <= blank2 ? pix.b : 8'd0;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: table vectors, hand sequences and random
// raster positions checked against a behavioural model.
module tb_sprite_compositor;

  import sprite_pkg::*;

  localparam int NS = 6;
  localparam int A_EN = 2 * NS;
  localparam int A_BG = 2 * NS + 1;
  localparam logic [23:0] RED  = 24'hFF0000;
  localparam logic [23:0] GRN  = 24'h00FF00;
  localparam logic [23:0] BLU  = 24'h0000FF;
  localparam logic [23:0] BG1  = 24'h102030;
  localparam logic [23:0] WHT  = 24'hFFFFFF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic chipselect = 1'b0;
  logic write = 1'b0;
  logic [8:0] address = '0;
  logic [31:0] writedata = '0;
  logic [10:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic blank_n_in = 1'b0;
  logic [NS*10-1:0] rom_addr;
  logic [NS*16-1:0] rom_data;
  logic [7:0] vga_r, vga_g, vga_b;
  logic blank_n_out;

  always #10 clk = ~clk;

  sprite_compositor #(.NUM_SPRITES(NS)) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .address     (address),
    .writedata   (writedata),
    .hcount      (hcount),
    .vcount      (vcount),
    .blank_n_in  (blank_n_in),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .blank_n_out (blank_n_out)
  );

  // sprite ROM: constant per sprite, or a fixed pattern of the address
  bit rom_mode = 1'b0;
  logic [15:0] rom_const [NS];

  function automatic logic [15:0] romf(int i, int a);
    if ((a + 3 * i) % 5 == 0) return 16'hF81F;
    return 16'((a * 37 + i * 4099 + 11) & 32'hFFFF);
  endfunction

  for (genvar i = 0; i < NS; i++) begin : g_rom
    assign rom_data[16*i +: 16] = rom_mode ?
      romf(i, int'(rom_addr[10*i +: 10])) : rom_const[i];
  end

  // behavioural register model
  int px_p [NS], py_p [NS], ax [NS], ay [NS];
  logic [NS-1:0] pen, aen;
  logic [23:0] pbg, abg;

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      px_p[i] = 0; py_p[i] = 0; ax[i] = 0; ay[i] = 0;
    end
    pen = '0; aen = '0; pbg = 24'hFFFFFF; abg = 24'hFFFFFF;
  endfunction

  function automatic void model_write(int adr, logic [31:0] wd);
    if (adr < 2 * NS) begin
      if (adr % 2 == 1) py_p[adr / 2] = int'(wd[9:0]);
      else px_p[adr / 2] = int'(wd[9:0]);
    end else if (adr == A_EN) pen = wd[NS-1:0];
    else if (adr == A_BG) pbg = wd[23:0];
  endfunction

  function automatic logic [23:0] expand(logic [15:0] d);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(d[15:11]); g6 = int'(d[10:5]); b5 = int'(d[4:0]);
    r8 = (r5 * 8) + (r5 / 4);
    g8 = (g6 * 4) + (g6 / 16);
    b8 = (b5 * 8) + (b5 / 4);
    return {8'(r8), 8'(g8), 8'(b8)};
  endfunction

  function automatic logic [24:0] model_pix(int px, int ln, bit bn);
    if (!bn) return '0;
    for (int i = 0; i < NS; i++) begin
      int dx = px - ax[i];
      int dy = ln - ay[i];
      if (aen[i] && dx >= 0 && dx < 32 && dy >= 0 && dy < 32) begin
        logic [15:0] d;
        d = rom_mode ? romf(i, dy * 32 + dx) : rom_const[i];
        if (d != 16'hF81F) return {1'b1, expand(d)};
      end
    end
    return {1'b1, abg};
  endfunction

  typedef struct {
    logic [24:0] v;
    string tag;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  bit hlsb = 1'b0;

  function automatic void check(string tag, logic [24:0] act, logic [24:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endfunction

  task automatic step(input int px, input int ln, input bit bn,
                      input bit we, input int adr, input logic [31:0] wd,
                      input bit rst, input bit fix, input logic [24:0] fexp,
                      input string tag);
    exp_t e;
    reset = rst;
    chipselect = we;
    write = we;
    address = 9'(adr);
    writedata = wd;
    hcount = {10'(px), hlsb};
    vcount = 10'(ln);
    blank_n_in = bn;
    if (rst) begin
      q.delete();
      e.v = '0;
      e.tag = tag;
      repeat (3) q.push_back(e);
      model_reset();
    end else begin
      e.v = fix ? fexp : model_pix(px, ln, bn);
      e.tag = tag;
      q.push_back(e);
      if (ln == 480 && hcount == 11'd0) begin
        ax = px_p; ay = py_p; aen = pen; abg = pbg;
      end
      if (we) model_write(adr, wd);
    end
    @(posedge clk);
    #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      check(e.tag, {blank_n_out, vga_r, vga_g, vga_b}, e.v);
    end
    reset = 1'b0;
    chipselect = 1'b0;
    write = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, '0, 0, 0, '0, "idle");
  endtask

  task automatic drain();
    repeat (3) idle();
  endtask

  task automatic wr(input int adr, input logic [31:0] wd, input int ln);
    step(0, ln, 0, 1, adr, wd, 0, 0, '0, "write");
  endtask

  task automatic commit(input bit we, input int adr, input logic [31:0] wd);
    idle();
    idle();
    step(0, 480, 0, we, adr, wd, 0, 0, '0, "commit");
  endtask

  task automatic pxc(input int px, input int ln, input logic [23:0] rgb,
                     input string tag);
    step(px, ln, 1, 0, 0, '0, 0, 1, {1'b1, rgb}, tag);
  endtask

  typedef struct {
    int px;
    int ln;
    bit bn;
    logic [23:0] rgb;
    string tag;
  } vec_t;

  vec_t tbl_bg[$];
  vec_t tbl_s0[$];

  task automatic run_tbl(input vec_t t[$]);
    foreach (t[k]) begin
      step(t[k].px, t[k].ln, t[k].bn, 0, 0, '0, 0, 1,
           t[k].bn ? {1'b1, t[k].rgb} : 25'd0, t[k].tag);
    end
  endtask

  initial begin
    tbl_bg.push_back('{50, 60, 1, BG1, "bg_mid"});
    tbl_bg.push_back('{639, 479, 1, BG1, "bg_corner"});
    tbl_bg.push_back('{0, 0, 1, BG1, "bg_origin"});
    tbl_bg.push_back('{300, 200, 0, 24'h0, "bg_blank"});
    tbl_bg.push_back('{301, 200, 1, BG1, "bg_after_blank"});
    tbl_s0.push_back('{100, 100, 1, RED, "s0_tl"});
    tbl_s0.push_back('{131, 100, 1, RED, "s0_tr"});
    tbl_s0.push_back('{100, 131, 1, RED, "s0_bl"});
    tbl_s0.push_back('{131, 131, 1, RED, "s0_br"});
    tbl_s0.push_back('{99, 100, 1, BG1, "s0_left_out"});
    tbl_s0.push_back('{132, 100, 1, BG1, "s0_right_out"});
    tbl_s0.push_back('{100, 99, 1, BG1, "s0_top_out"});
    tbl_s0.push_back('{100, 132, 1, BG1, "s0_bot_out"});
    tbl_s0.push_back('{115, 115, 0, 24'h0, "s0_blank"});

    for (int i = 0; i < NS; i++) rom_const[i] = 16'h0000;
    model_reset();

    // reset state
    step(0, 0, 0, 0, 0, '0, 1, 0, '0, "reset");
    check("reset_rom_addr", 25'(rom_addr), 25'd0);
    step(0, 0, 0, 0, 0, '0, 1, 0, '0, "reset2");

    // background only
    wr(A_BG, 32'h0010_2030, 0);
    wr(A_EN, 32'h0, 0);
    commit(0, 0, '0);
    run_tbl(tbl_bg);

    // single red sprite
    drain();
    rom_const[0] = 16'hF800;
    wr(0, 32'd100, 0);
    wr(1, 32'd100, 0);
    wr(A_EN, 32'h1, 0);
    commit(0, 0, '0);
    run_tbl(tbl_s0);
    pxc(105, 102, RED, "s0_addr_px");
    check("rom_addr_105_102", 25'(rom_addr[9:0]), 25'd69);
    pxc(50, 50, BG1, "s0_miss");
    check("rom_addr_hold", 25'(rom_addr[9:0]), 25'd69);

    // two sprites stacked, colour key on the top one
    drain();
    rom_const[0] = 16'hF81F;
    rom_const[1] = 16'h07E0;
    wr(2, 32'd100, 0);
    wr(3, 32'd100, 0);
    wr(A_EN, 32'h3, 0);
    commit(0, 0, '0);
    pxc(110, 110, GRN, "key_passthru");
    drain();
    rom_const[0] = 16'h001F;
    pxc(110, 110, BLU, "prio_top");

    // mid-frame write stays pending until commit
    wr(0, 32'd300, 200);
    pxc(100, 120, BLU, "pend_old_pos");
    pxc(300, 120, BG1, "pend_new_hidden");
    commit(0, 0, '0);
    pxc(100, 120, GRN, "commit_old_gone");
    pxc(300, 120, BLU, "commit_new_pos");
    commit(1, 0, 32'd500);
    pxc(300, 120, BLU, "cwr_not_yet");
    pxc(500, 120, BG1, "cwr_hidden");
    commit(0, 0, '0);
    pxc(500, 120, BLU, "cwr_next_frame");
    pxc(300, 120, BG1, "cwr_old_gone");

    // right/bottom edge sprite must not wrap
    drain();
    rom_const[0] = 16'hF800;
    wr(0, 32'd630, 0);
    wr(1, 32'd470, 0);
    wr(A_EN, 32'h1, 0);
    commit(0, 0, '0);
    pxc(630, 470, RED, "edge_tl");
    pxc(639, 479, RED, "edge_br");
    pxc(629, 470, BG1, "edge_left_out");
    pxc(630, 469, BG1, "edge_top_out");
    pxc(0, 470, BG1, "nowrap_px0");
    pxc(9, 475, BG1, "nowrap_px9");
    pxc(630, 0, BG1, "nowrap_ln0");
    pxc(635, 9, BG1, "nowrap_ln9");
    for (int p = 600; p < 640; p++) pxc(p, 475, (p >= 630) ? RED : BG1, "edge_cols");
    for (int l = 440; l < 480; l++) pxc(632, l, (l >= 470) ? RED : BG1, "edge_rows");

    // write past the register map, then reset mid-frame
    wr(A_BG + 1, 32'hFFFF_FFFF, 0);
    commit(0, 0, '0);
    pxc(630, 470, RED, "badwr_pos");
    pxc(100, 100, BG1, "badwr_bg");
    step(100, 240, 1, 0, 0, '0, 1, 0, '0, "midframe_reset");
    check("reset_rom_addr2", 25'(rom_addr), 25'd0);
    pxc(100, 100, WHT, "post_reset_bg");
    pxc(630, 470, WHT, "post_reset_dis");
    pxc(200, 300, WHT, "post_reset_lat");

    // random raster against the model
    drain();
    rom_mode = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < NS; i++) begin
        int xv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(600, 639))
                                             : int'($urandom_range(0, 639));
        int yv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(450, 479))
                                             : int'($urandom_range(0, 479));
        wr(2 * i, {22'($urandom), 10'(xv)}, 0);
        wr(2 * i + 1, {22'($urandom), 10'(yv)}, 0);
      end
      wr(A_EN, $urandom, 0);
      wr(A_BG, $urandom, 0);
      commit(0, 0, '0);
      hlsb = 1'b1;
      for (int k = 0; k < 300; k++) begin
        int s = int'($urandom_range(0, NS - 1));
        int px = ax[s] - 3 + int'($urandom_range(0, 37));
        int ln = ay[s] - 3 + int'($urandom_range(0, 37));
        hlsb = 1'($urandom);
        if (px < 0) px = 0;
        if (px > 1023) px = 1023;
        if (ln < 0) ln = 0;
        if (ln > 1023) ln = 1023;
        if (ln == 480) ln = 481;
        if ($urandom_range(0, 19) == 0)
          step(px, ln, 0, 1, int'($urandom_range(0, 15)), $urandom,
               0, 0, '0, "rand_wr");
        else
          step(px, ln, $urandom_range(0, 7) != 0, 0, 0, '0,
               0, 0, '0, "rand");
      end
      hlsb = 1'b0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
